// File: rtl/alu_result_stage.sv
// Result-capture stage behind the combinational ALU: latches c_lo/c_hi into Z,
// and into HI/LO for multiply/divide after a programmable number of settle cycles.
module alu_result_stage #(
  parameter int MUL_WAIT = 3,
  parameter int DIV_WAIT = 8
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [3:0]  ctrl,
  input  logic [31:0] c_lo_in,
  input  logic [31:0] c_hi_in,
  output logic [31:0] z_lo_out,
  output logic [31:0] z_hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] hi_out,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        dbg_wait,
  output logic [3:0]  dbg_op
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int MAX_WAIT = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
  localparam int CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_WAIT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_WAIT - 1);

  state_t        state, state_d;
  logic [CW-1:0] count, count_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   z_lo_d, z_hi_d, lo_d, hi_d;
  logic          busy_d, done_d, illegal_d;

  // Handshake: start is sampled only in IDLE; every accepted start yields exactly
  // one registered done pulse, and start seen in WAIT is dropped without trace.
  always_comb begin
    state_d   = state;
    count_d   = count;
    op_d      = op_q;
    z_lo_d    = z_lo_out;
    z_hi_d    = z_hi_out;
    lo_d      = lo_out;
    hi_d      = hi_out;
    busy_d    = busy;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          op_d = ctrl;
          if (ctrl <= 4'd9) begin
            z_lo_d = c_lo_in;
            z_hi_d = 32'd0;
            done_d = 1'b1;
          end else if (ctrl <= 4'd11) begin
            count_d = (ctrl == 4'd10) ? MUL_LOAD : DIV_LOAD;
            state_d = WAIT;
            busy_d  = 1'b1;
          end else begin
            done_d    = 1'b1;
            illegal_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (count != '0) begin
          count_d = count - 1'b1;
        end else begin
          // ALU outputs have settled for the full multicycle window
          z_lo_d  = c_lo_in;
          z_hi_d  = c_hi_in;
          lo_d    = c_lo_in;
          hi_d    = c_hi_in;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= 4'd0;
      z_lo_out <= 32'd0;
      z_hi_out <= 32'd0;
      lo_out   <= 32'd0;
      hi_out   <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      op_q     <= op_d;
      z_lo_out <= z_lo_d;
      z_hi_out <= z_hi_d;
      lo_out   <= lo_d;
      hi_out   <= hi_d;
      busy     <= busy_d;
      done     <= done_d;
      illegal  <= illegal_d;
    end
  end

  assign dbg_wait = (state == WAIT);
  assign dbg_op   = op_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: table of single-cycle ops issued back-to-back,
// then hand-written multiply/divide/reset/illegal/back-to-back sequences.
module tb_alu_result_stage;

  localparam int MUL_WAIT = 3;
  localparam int DIV_WAIT = 8;

  logic        clock = 1'b0;
  logic        clear_n, start;
  logic [3:0]  ctrl;
  logic [31:0] c_lo_in, c_hi_in;
  logic [31:0] z_lo_out, z_hi_out, lo_out, hi_out;
  logic        busy, done, illegal, dbg_wait;
  logic [3:0]  dbg_op;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int busy_run = 0;

  typedef struct packed {
    logic [31:0] z_lo;
    logic [31:0] z_hi;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ill;
    logic [15:0] cyc;
    logic [7:0]  busy_n;
  } exp_t;
  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] c_lo, c_hi;
    logic [31:0] z_lo, z_hi, lo, hi;
    logic        ill;
  } vec_t;
  vec_t vecs[8];

  alu_result_stage #(.MUL_WAIT(MUL_WAIT), .DIV_WAIT(DIV_WAIT)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .ctrl(ctrl),
    .c_lo_in(c_lo_in), .c_hi_in(c_hi_in),
    .z_lo_out(z_lo_out), .z_hi_out(z_hi_out), .lo_out(lo_out), .hi_out(hi_out),
    .busy(busy), .done(done), .illegal(illegal),
    .dbg_wait(dbg_wait), .dbg_op(dbg_op)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // driver: drive one start for a single edge and queue its expected result
  task automatic issue(input logic [3:0] op, input logic [31:0] lo_v, input logic [31:0] hi_v,
                       input logic [31:0] ez_lo, input logic [31:0] ez_hi,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input logic eill, input int n);
    exp_t e;
    e.z_lo   = ez_lo;
    e.z_hi   = ez_hi;
    e.lo     = elo;
    e.hi     = ehi;
    e.ill    = eill;
    e.cyc    = 16'(cyc + 1 + n);
    e.busy_n = 8'(n);
    ctrl    = op;
    c_lo_in = lo_v;
    c_hi_in = hi_v;
    start   = 1'b1;
    exp_q.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_z_lo"}, z_lo_out, 32'd0);
    check({tag, "_z_hi"}, z_hi_out, 32'd0);
    check({tag, "_lo"}, lo_out, 32'd0);
    check({tag, "_hi"}, hi_out, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  // scoreboard: every done pops one expected record
  always @(negedge clock) begin
    exp_t e;
    if (busy === 1'b1) busy_run++;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc, {16'd0, e.cyc});
        check("busy_cycles", busy_run, {24'd0, e.busy_n});
        check("z_lo", z_lo_out, e.z_lo);
        check("z_hi", z_hi_out, e.z_hi);
        check("lo", lo_out, e.lo);
        check("hi", hi_out, e.hi);
        check("illegal", {31'd0, illegal}, {31'd0, e.ill});
      end
      busy_run = 0;
    end else if (illegal === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL illegal_without_done: got illegal=1 expected 0 at cycle %0d", cyc);
    end
  end

  initial begin
    vecs[0] = '{4'd2,  32'h0000_0007, 32'hDEAD_BEEF, 32'h0000_0007, 32'd0, 32'd0, 32'd0, 1'b0};
    vecs[1] = '{4'd0,  32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0};
    vecs[2] = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b0};
    vecs[3] = '{4'd13, 32'h0000_AAAA, 32'h0000_BBBB, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b1};
    vecs[4] = '{4'd5,  32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'd0, 32'd0, 32'd0, 1'b0};
    vecs[5] = '{4'd15, 32'h0BAD_F00D, 32'h0000_0001, 32'h0000_0000, 32'd0, 32'd0, 32'd0, 1'b1};
    vecs[6] = '{4'd12, 32'h0000_1111, 32'h0000_2222, 32'h0000_0000, 32'd0, 32'd0, 32'd0, 1'b1};
    vecs[7] = '{4'd1,  32'hA5A5_5A5A, 32'h5A5A_A5A5, 32'hA5A5_5A5A, 32'd0, 32'd0, 32'd0, 1'b0};

    clear_n = 1'b0;
    start   = 1'b0;
    ctrl    = 4'd0;
    c_lo_in = 32'd0;
    c_hi_in = 32'd0;
    repeat (3) tick();
    check_zero("reset");
    clear_n = 1'b1;
    tick();

    // single-cycle ops, one start per cycle
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].ctrl, vecs[i].c_lo, vecs[i].c_hi, vecs[i].z_lo, vecs[i].z_hi,
            vecs[i].lo, vecs[i].hi, vecs[i].ill, 0);
    end
    drain(10);

    // multiply: ALU outputs wander until the last settle cycle
    issue(4'd10, $urandom, 32'($urandom_range(2, 1000)), 32'h8000_0000, 32'h1,
          32'h8000_0000, 32'h1, 1'b0, MUL_WAIT);
    c_lo_in = $urandom;
    c_hi_in = 32'($urandom_range(2, 1000));
    tick();
    c_lo_in = $urandom;
    c_hi_in = 32'($urandom_range(2, 1000));
    tick();
    c_lo_in = 32'h8000_0000;
    c_hi_in = 32'h0000_0001;
    drain(20);

    // back-to-back: start an OR in the cycle done is high for a multiply
    issue(4'd10, 32'h0000_0003, 32'h0000_0002, 32'h3, 32'h2, 32'h3, 32'h2, 1'b0, MUL_WAIT);
    repeat (MUL_WAIT) tick();
    check("b2b_done_high", {31'd0, done}, 32'd1);
    issue(4'd1, 32'h0000_0F0F, 32'h0000_0077, 32'h0F0F, 32'h0, 32'h3, 32'h2, 1'b0, 0);
    drain(10);

    // divide with stray start pulses during WAIT
    issue(4'd11, 32'h0000_1111, 32'h0000_2222, 32'h1111, 32'h2222, 32'h1111, 32'h2222,
          1'b0, DIV_WAIT);
    for (int j = 1; j <= DIV_WAIT; j++) begin
      start = (j % 3 == 2);
      tick();
    end
    start = 1'b0;
    drain(20);

    // illegal opcode leaves Z/HI/LO alone
    issue(4'd13, 32'hAAAA_0000, 32'hBBBB_0000, 32'h1111, 32'h2222, 32'h1111, 32'h2222, 1'b1, 0);
    drain(10);

    // reset in the middle of a divide
    issue(4'd11, 32'h0000_5555, 32'h0000_6666, 32'h5555, 32'h6666, 32'h5555, 32'h6666,
          1'b0, DIV_WAIT);
    repeat (3) tick();
    clear_n = 1'b0;
    tick();
    exp_q.delete();
    busy_run = 0;
    check_zero("mid_reset");
    clear_n = 1'b1;
    repeat (12) tick();
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    issue(4'd3, 32'h0000_0099, 32'h0000_1234, 32'h99, 32'h0, 32'h0, 32'h0, 1'b0, 0);
    drain(10);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
